// File: rtl/wb_regfile_if.sv
// Write-back stage bundle: MEM/WB operands in, decode read ports, and retirement status out.
// master = pipeline side, slave = register file.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              wb_valid;
    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic              wb_link;
    logic [DATA_W-1:0] wb_mem_data;
    logic [DATA_W-1:0] wb_alu_res;
    logic [DATA_W-1:0] wb_pc_plus8;
    logic [4:0]        wb_write_reg;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              commit;
    logic [4:0]        commit_reg;
    logic [DATA_W-1:0] commit_data;
    logic [CNT_W-1:0]  retire_count;

    modport master (
        output wb_valid, wb_reg_write, wb_mem_to_reg, wb_link,
        output wb_mem_data, wb_alu_res, wb_pc_plus8, wb_write_reg,
        output rs_addr, rt_addr,
        input  rs_data, rt_data, commit, commit_reg, commit_data, retire_count
    );

    modport slave (
        input  wb_valid, wb_reg_write, wb_mem_to_reg, wb_link,
        input  wb_mem_data, wb_alu_res, wb_pc_plus8, wb_write_reg,
        input  rs_addr, rt_addr,
        output rs_data, rt_data, commit, commit_reg, commit_data, retire_count
    );
endinterface

// File: rtl/wb_regfile.sv
// 32-entry register file with write-back mux, commit report and retired-instruction counter.
// Define WB_BYPASS_EN to forward the in-flight write value to same-cycle reads.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic         clock,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    localparam int N_REGS = 32;

    logic [DATA_W-1:0] regs_r [N_REGS];
    logic [DATA_W-1:0] wr_data_s;
    logic [4:0]        wr_idx_s;
    logic              we_s;
    logic              retire_s;
    logic [DATA_W-1:0] rs_data_s;
    logic [DATA_W-1:0] rt_data_s;
    logic              commit_r;
    logic [4:0]        commit_reg_r;
    logic [DATA_W-1:0] commit_data_r;
    logic [CNT_W-1:0]  retire_count_r;

    // Register 0 is hardwired to zero regardless of array contents.
    function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
        logic [DATA_W-1:0] val;
        if (addr == 5'd0) begin
            val = {DATA_W{1'b0}};
        end
`ifdef WB_BYPASS_EN
        else if (we_s && (addr == wr_idx_s)) begin
            val = wr_data_s;
        end
`endif
        else begin
            val = regs_r[addr];
        end
        return val;
    endfunction

    // Write value select: link address outranks load data, which outranks the ALU result.
    always_comb begin
        wr_data_s = bus.wb_alu_res;
        if (bus.wb_link) begin
            wr_data_s = bus.wb_pc_plus8;
        end else if (bus.wb_mem_to_reg) begin
            wr_data_s = bus.wb_mem_data;
        end else begin
            wr_data_s = bus.wb_alu_res;
        end
    end

    // Write enable; bubbles and writes to r0 never reach the array or the commit report.
    always_comb begin
        wr_idx_s = bus.wb_write_reg;
        retire_s = bus.wb_valid;
        we_s     = 1'b0;
        if (bus.wb_valid && bus.wb_reg_write && (bus.wb_write_reg != 5'd0)) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    // Combinational read ports.
    always_comb begin
        rs_data_s = read_port(bus.rs_addr);
        rt_data_s = read_port(bus.rt_addr);
    end

    // Register array update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we_s) begin
            regs_r[wr_idx_s] <= wr_data_s;
        end
    end

    // Commit report: one-cycle-delayed copy of each retired register write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commit_r      <= 1'b0;
            commit_reg_r  <= 5'd0;
            commit_data_r <= {DATA_W{1'b0}};
        end else begin
            commit_r <= we_s;
            if (we_s) begin
                commit_reg_r  <= wr_idx_s;
                commit_data_r <= wr_data_s;
            end
        end
    end

    // Retired-instruction counter; wraps silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retire_count_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            retire_count_r <= retire_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.rs_data      = rs_data_s;
    assign bus.rt_data      = rt_data_s;
    assign bus.commit       = commit_r;
    assign bus.commit_reg   = commit_reg_r;
    assign bus.commit_data  = commit_data_r;
    assign bus.retire_count = retire_count_r;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: hand-computed vectors, driven on negedge, sampled 1 ns after posedge.
module tb_wb_regfile;
    logic clock;
    logic reset;
    int   n_total;
    int   n_pass;

    wb_regfile_if #(.DATA_W(32), .CNT_W(32)) bus ();

    wb_regfile #(.DATA_W(32), .CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic lnk,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc8, input logic [4:0] wreg);
        bus.wb_valid      = v;
        bus.wb_reg_write  = rw;
        bus.wb_mem_to_reg = m2r;
        bus.wb_link       = lnk;
        bus.wb_alu_res    = alu;
        bus.wb_mem_data   = mem;
        bus.wb_pc_plus8   = pc8;
        bus.wb_write_reg  = wreg;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset   = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        bus.rs_addr = 5'd5;
        bus.rt_addr = 5'd31;
        #12;
        check("rst_commit", {31'd0, bus.commit}, 32'h0);
        check("rst_commit_reg", {27'd0, bus.commit_reg}, 32'h0);
        check("rst_commit_data", bus.commit_data, 32'h0);
        check("rst_retire", bus.retire_count, 32'h0);
        check("rst_rs_r5", bus.rs_data, 32'h0);

        @(negedge clock);
        reset = 1'b0;

        // ALU write to r5
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 5'd5);
        bus.rs_addr = 5'd5;
        tick();
        check("alu_r5", bus.rs_data, 32'h0000_1234);
        check("alu_commit", {31'd0, bus.commit}, 32'h1);
        check("alu_commit_reg", {27'd0, bus.commit_reg}, 32'd5);
        check("alu_commit_data", bus.commit_data, 32'h0000_1234);
        check("alu_retire", bus.retire_count, 32'd1);

        // write to r0 is dropped but still retires
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0);
        bus.rs_addr = 5'd0;
        tick();
        check("r0_read", bus.rs_data, 32'h0);
        check("r0_commit", {31'd0, bus.commit}, 32'h0);
        check("r0_retire", bus.retire_count, 32'd2);

        // bubble with reg_write set
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_9999, 32'h0, 32'h0, 5'd6);
        bus.rs_addr = 5'd6;
        tick();
        check("bubble_r6", bus.rs_data, 32'h0);
        check("bubble_commit", {31'd0, bus.commit}, 32'h0);
        check("bubble_retire", bus.retire_count, 32'd2);

        // valid non-writing instruction
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_7777, 32'h0, 32'h0, 5'd6);
        tick();
        check("nowr_r6", bus.rs_data, 32'h0);
        check("nowr_commit", {31'd0, bus.commit}, 32'h0);
        check("nowr_retire", bus.retire_count, 32'd3);

        // load data select
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1111, 32'hCAFE_0001, 32'h0000_2222, 5'd9);
        bus.rs_addr = 5'd9;
        tick();
        check("load_r9", bus.rs_data, 32'hCAFE_0001);
        check("load_commit_data", bus.commit_data, 32'hCAFE_0001);
        check("load_retire", bus.retire_count, 32'd4);

        // link outranks mem_to_reg
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_3333, 32'hDEAD_BEEF, 32'h0040_0008, 5'd31);
        bus.rt_addr = 5'd31;
        tick();
        check("link_r31", bus.rt_data, 32'h0040_0008);
        check("link_commit_reg", {27'd0, bus.commit_reg}, 32'd31);
        check("link_retire", bus.retire_count, 32'd5);

        // same-cycle read of the register being written
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5, 32'h0, 32'h0, 5'd7);
        bus.rt_addr = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        check("pre_edge_r7", bus.rt_data, 32'hA5A5_A5A5);
`else
        check("pre_edge_r7", bus.rt_data, 32'h0);
`endif
        check("pre_edge_r9", bus.rs_data, 32'hCAFE_0001);
        tick();
        check("post_edge_r7", bus.rt_data, 32'hA5A5_A5A5);
        check("post_edge_retire", bus.retire_count, 32'd6);

        // back-to-back writes to r3
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0011, 32'h0, 32'h0, 5'd3);
        bus.rs_addr = 5'd3;
        tick();
        check("b2b1_commit", {31'd0, bus.commit}, 32'h1);
        check("b2b1_data", bus.commit_data, 32'h0000_0011);
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0022, 32'h0, 32'h0, 5'd3);
        tick();
        check("b2b2_commit", {31'd0, bus.commit}, 32'h1);
        check("b2b2_data", bus.commit_data, 32'h0000_0022);
        check("b2b2_r3", bus.rs_data, 32'h0000_0022);
        check("b2b2_retire", bus.retire_count, 32'd8);

        // idle cycle drops commit; other registers untouched
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        bus.rt_addr = 5'd5;
        tick();
        check("idle_commit", {31'd0, bus.commit}, 32'h0);
        check("idle_r5", bus.rt_data, 32'h0000_1234);
        check("idle_retire", bus.retire_count, 32'd8);

        // counter wrap
        @(negedge clock);
        force dut.retire_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count_r;
        #1;
        check("wrap_preset", bus.retire_count, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        check("wrap_zero", bus.retire_count, 32'h0);

        // asynchronous reset between edges
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 32'h0, 5'd3);
        bus.rs_addr = 5'd3;
        tick();
        check("pre_rst_r3", bus.rs_data, 32'h0000_0055);
        check("pre_rst_commit", {31'd0, bus.commit}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_r3", bus.rs_data, 32'h0);
        check("arst_commit", {31'd0, bus.commit}, 32'h0);
        check("arst_retire", bus.retire_count, 32'h0);
        tick();
        check("rst_edge_r3", bus.rs_data, 32'h0);
        check("rst_edge_retire", bus.retire_count, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 32'h0, 5'd4);
        bus.rs_addr = 5'd4;
        tick();
        check("post_rst_r4", bus.rs_data, 32'h0000_0077);
        check("post_rst_commit", {31'd0, bus.commit}, 32'h1);
        check("post_rst_retire", bus.retire_count, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
